// File: rtl/alu_shift_pipe_pkg.sv
// Shared types for the two-stage shift pipe: op encoding and shift-amount width.
package alu_shift_pipe_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRor = 2'b11
  } shift_op_e;

  localparam int unsigned ShamtW = 5;

endpackage

// File: rtl/alu_shift_pipe_shift_step.sv
// One conditional shift level of the shift network: shifts by DIST when en_i is set.
module alu_shift_pipe_shift_step
  import alu_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  shift_op_e        op_i,
  input  logic             sign_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      unique case (op_i)
        OpSll: data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
        OpSrl: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        // Fill from the operand's original sign, not the partial result's MSB.
        OpSra: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        OpRor: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage pipelined 32-bit shifter (SLL/SRL/SRA/ROR) with valid/ready flow control and flush.
module alu_shift_pipe
  import alu_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [ShamtW-1:0] in_shamt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  shift_op_e        s1_op_q, s1_op_d;
  logic [2:0]       s1_lo_q, s1_lo_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s1_adv, s2_adv;
  shift_op_e        in_op_e;
  logic [WIDTH-1:0] p16, p8, p4, p2, p1;

  assign in_op_e = shift_op_e'(in_op);

  // Stage 1 network: coarse shifts by 16 and 8.
  alu_shift_pipe_shift_step #(.WIDTH(WIDTH), .DIST(16)) u_step16 (
    .op_i(in_op_e), .sign_i(in_data[WIDTH-1]), .en_i(in_shamt[4]), .data_i(in_data), .data_o(p16)
  );
  alu_shift_pipe_shift_step #(.WIDTH(WIDTH), .DIST(8)) u_step8 (
    .op_i(in_op_e), .sign_i(in_data[WIDTH-1]), .en_i(in_shamt[3]), .data_i(p16), .data_o(p8)
  );

  // Stage 2 network: fine shifts by 4, 2 and 1 on the registered partial.
  alu_shift_pipe_shift_step #(.WIDTH(WIDTH), .DIST(4)) u_step4 (
    .op_i(s1_op_q), .sign_i(s1_sign_q), .en_i(s1_lo_q[2]), .data_i(s1_data_q), .data_o(p4)
  );
  alu_shift_pipe_shift_step #(.WIDTH(WIDTH), .DIST(2)) u_step2 (
    .op_i(s1_op_q), .sign_i(s1_sign_q), .en_i(s1_lo_q[1]), .data_i(p4), .data_o(p2)
  );
  alu_shift_pipe_shift_step #(.WIDTH(WIDTH), .DIST(1)) u_step1 (
    .op_i(s1_op_q), .sign_i(s1_sign_q), .en_i(s1_lo_q[0]), .data_i(p2), .data_o(p1)
  );

  assign s2_adv    = !s2_v_q || out_ready;
  assign s1_adv    = !s1_v_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_v_q || s2_v_q;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_op_d   = s1_op_q;
    s1_lo_d   = s1_lo_q;
    s1_sign_d = s1_sign_q;
    s1_data_d = s1_data_q;
    s1_tag_d  = s1_tag_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    if (flush) begin
      // Flush kills everything in flight and refuses the op being offered.
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_v_d = s1_v_q;
        if (s1_v_q) begin
          s2_data_d = p1;
          s2_tag_d  = s1_tag_q;
        end
      end
      if (s1_adv) begin
        s1_v_d = in_valid;
        if (in_valid) begin
          s1_op_d   = in_op_e;
          s1_lo_d   = in_shamt[2:0];
          s1_sign_d = in_data[WIDTH-1];
          s1_data_d = p8;
          s1_tag_d  = in_tag;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_op_q   <= OpSll;
      s1_lo_q   <= '0;
      s1_sign_q <= 1'b0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_op_q   <= s1_op_d;
      s1_lo_q   <= s1_lo_d;
      s1_sign_q <= s1_sign_d;
      s1_data_q <= s1_data_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

endmodule
